// File: rtl/multi_zone_light_ctrl.sv
// multi_zone_light_ctrl: per-zone PIR-driven lighting controller.
// Each zone debounces its PIR input, runs an OFF/ON/HOLD state machine with a
// programmable hold-off timer and pre-off warning, and can be overridden
// manually. Daylight blocks only the OFF->ON transition.
//
// Handshake note: this block has no valid/ready interfaces. All inputs are
// sampled on every rising clk edge and all outputs are continuously valid,
// combinational from registered state, override inputs and reset.
module multi_zone_light_ctrl #(
  parameter int ZONES       = 4,
  parameter int HOLD_W      = 16,
  parameter int DEB_LEN     = 3,
  parameter int WARN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ZONES-1:0]           pir,
  input  logic [HOLD_W-1:0]          hold_time,
  input  logic                       daylight,
  input  logic [ZONES-1:0]           ovr_en,
  input  logic [ZONES-1:0]           ovr_val,
  output logic [ZONES-1:0]           light,
  output logic [ZONES-1:0]           warn,
  output logic [$clog2(ZONES+1)-1:0] occupied_cnt,
  output logic                       any_on,
  output logic [2*ZONES-1:0]         dbg_state
);

  localparam int CNT_W = $clog2(DEB_LEN + 1);
  localparam int OCC_W = $clog2(ZONES + 1);
  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEB_LEN);
  localparam logic [CNT_W-1:0]  DEB_THR  = CNT_W'(DEB_LEN - 1);
  localparam logic [HOLD_W-1:0] WARN_THR = HOLD_W'(WARN_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state     [ZONES];
  state_t              w_state_nxt [ZONES];
  logic [HOLD_W-1:0]   r_timer     [ZONES];
  logic [HOLD_W-1:0]   w_timer_nxt [ZONES];
  logic [CNT_W-1:0]    r_deb       [ZONES];
  logic [ZONES-1:0]    w_qual;
  logic [ZONES-1:0]    w_light;
  logic [ZONES-1:0]    w_warn;
  logic [OCC_W-1:0]    w_occ;

  // Qualification uses the counter value before this edge's update, so the
  // qualifying edge is the one completing DEB_LEN consecutive high samples.
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < ZONES; i++) begin
      w_qual[i] = pir[i] && (r_deb[i] >= DEB_THR);
    end
  end

  // Debounce counters: count consecutive high samples, saturate, clear on low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ZONES; i++) r_deb[i] <= '0;
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        if (!pir[i])
          r_deb[i] <= '0;
        else if (r_deb[i] != DEB_MAX)
          r_deb[i] <= r_deb[i] + CNT_W'(1);
      end
    end
  end

  // Per-zone state and hold timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ZONES; i++) begin
        r_state[i] <= ST_OFF;
        r_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_timer[i] <= w_timer_nxt[i];
      end
    end
  end

  // Next-state logic. Retrigger from HOLD ignores daylight; a fresh turn-on
  // from OFF is blocked by it. hold_time is captured only on ON->HOLD.
  always_comb begin
    for (int i = 0; i < ZONES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_timer_nxt[i] = r_timer[i];
      case (r_state[i])
        ST_OFF: begin
          if (w_qual[i] && !daylight) w_state_nxt[i] = ST_ON;
        end
        ST_ON: begin
          if (!pir[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_timer_nxt[i] = hold_time;
          end
        end
        ST_HOLD: begin
          if (w_qual[i])
            w_state_nxt[i] = ST_ON;
          else if (r_timer[i] == '0)
            w_state_nxt[i] = ST_OFF;
          else
            w_timer_nxt[i] = r_timer[i] - HOLD_W'(1);
        end
        default: begin
          w_state_nxt[i] = ST_OFF;
          w_timer_nxt[i] = '0;
        end
      endcase
    end
  end

  // Output mux: override wins over FSM, reset forces everything dark.
  always_comb begin
    w_light = '0;
    w_warn  = '0;
    for (int i = 0; i < ZONES; i++) begin
      if (!reset) begin
        w_light[i] = ovr_en[i] ? ovr_val[i] : (r_state[i] != ST_OFF);
        w_warn[i]  = !ovr_en[i] && (r_state[i] == ST_HOLD) && (r_timer[i] < WARN_THR);
      end
    end
  end

  // Occupancy count over the final light vector, override included.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < ZONES; i++) begin
      w_occ = w_occ + OCC_W'(w_light[i]);
    end
  end

  // Debug view of each zone's FSM state, zone i in bits [2i+1:2i].
  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < ZONES; i++) begin
      dbg_state[2*i +: 2] = r_state[i];
    end
  end

  assign light        = w_light;
  assign warn         = w_warn;
  assign occupied_cnt = w_occ;
  assign any_on       = |w_light;

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Directed testbench for multi_zone_light_ctrl (ZONES=4, DEB_LEN=3,
// WARN_CYCLES=2). The driver pushes hand-computed expected outputs into a
// queue; the monitor pops and compares at each negedge or on demand.
module tb_multi_zone_light_ctrl;

  localparam int ZONES  = 4;
  localparam int HOLD_W = 16;
  localparam int OCC_W  = 3;
  localparam int W      = 2*ZONES + OCC_W + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ZONES-1:0]     pir;
  logic [HOLD_W-1:0]    hold_time;
  logic                 daylight;
  logic [ZONES-1:0]     ovr_en;
  logic [ZONES-1:0]     ovr_val;
  logic [ZONES-1:0]     light;
  logic [ZONES-1:0]     warn;
  logic [OCC_W-1:0]     occupied_cnt;
  logic                 any_on;
  logic [2*ZONES-1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  event         sample_now;

  multi_zone_light_ctrl #(
    .ZONES(ZONES), .HOLD_W(HOLD_W), .DEB_LEN(3), .WARN_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .pir(pir), .hold_time(hold_time),
    .daylight(daylight), .ovr_en(ovr_en), .ovr_val(ovr_val),
    .light(light), .warn(warn), .occupied_cnt(occupied_cnt),
    .any_on(any_on), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Expected packing: {light, warn, popcount(light), |light}
  task automatic push(input logic [ZONES-1:0] el, input logic [ZONES-1:0] ew,
                      input string nm);
    logic [OCC_W-1:0] c;
    c = OCC_W'($countones(el));
    exp_q.push_back({el, ew, c, |el});
    name_q.push_back(nm);
  endtask

  // One clock edge with pir applied, expectation checked after the edge.
  task automatic step(input logic [ZONES-1:0] p, input logic [ZONES-1:0] el,
                      input logic [ZONES-1:0] ew, input string nm);
    pir = p;
    @(posedge clk);
    #1;
    push(el, ew, nm);
    @(negedge clk);
    #1;
  endtask

  // Check combinational response right now, with no clock edge in between.
  task automatic now_chk(input logic [ZONES-1:0] el, input logic [ZONES-1:0] ew,
                         input string nm);
    #1;
    push(el, ew, nm);
    -> sample_now;
    #1;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    string        nm;
    forever begin
      @(negedge clk or sample_now);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {light, warn, occupied_cnt, any_on};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got light=%b warn=%b cnt=%0d any=%b, want light=%b warn=%b cnt=%0d any=%b",
                   nm, got[W-1 -: ZONES], got[W-1-ZONES -: ZONES], got[OCC_W:1], got[0],
                   e[W-1 -: ZONES], e[W-1-ZONES -: ZONES], e[OCC_W:1], e[0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    reset     = 1'b1;
    pir       = 4'hF;
    hold_time = '0;
    daylight  = 1'b0;
    ovr_en    = 4'hF;
    ovr_val   = 4'hF;
    @(negedge clk);
    #1;

    // 1: reset dominates override; then DEB_LEN qualification
    now_chk(4'h0, 4'h0, "rst_ovr_now");
    step(4'hF, 4'h0, 4'h0, "rst_hold_a");
    step(4'hF, 4'h0, 4'h0, "rst_hold_b");
    reset  = 1'b0;
    ovr_en = 4'h0;
    step(4'hF, 4'h0, 4'h0, "deb_edge1");
    step(4'hF, 4'h0, 4'h0, "deb_edge2");
    step(4'hF, 4'hF, 4'h0, "deb_edge3_on");
    hold_time = 16'd0;
    step(4'h0, 4'hF, 4'hF, "hold0_one_cycle");
    step(4'h0, 4'h0, 4'h0, "hold0_off");

    // 2: glitch rejection on zone 0
    step(4'h1, 4'h0, 4'h0, "glitch_h1");
    step(4'h1, 4'h0, 4'h0, "glitch_h2");
    step(4'h0, 4'h0, 4'h0, "glitch_low");
    step(4'h1, 4'h0, 4'h0, "pulse_h1");
    step(4'h1, 4'h0, 4'h0, "pulse_h2");
    step(4'h1, 4'h1, 4'h0, "pulse_h3_on");

    // 3: hold_time=5 gives six lit cycles, warn on the last two
    hold_time = 16'd5;
    step(4'h0, 4'h1, 4'h0, "hold_t5");
    step(4'h0, 4'h1, 4'h0, "hold_t4");
    step(4'h0, 4'h1, 4'h0, "hold_t3");
    step(4'h0, 4'h1, 4'h0, "hold_t2");
    step(4'h0, 4'h1, 4'h1, "hold_t1_warn");
    step(4'h0, 4'h1, 4'h1, "hold_t0_warn");
    step(4'h0, 4'h0, 4'h0, "hold_expired");

    // 4: retrigger from HOLD, then reload with a new hold_time
    step(4'h1, 4'h0, 4'h0, "re_on_1");
    step(4'h1, 4'h0, 4'h0, "re_on_2");
    step(4'h1, 4'h1, 4'h0, "re_on_3");
    hold_time = 16'd7;
    step(4'h0, 4'h1, 4'h0, "re_hold_t7");
    step(4'h0, 4'h1, 4'h0, "re_hold_t6");
    step(4'h1, 4'h1, 4'h0, "re_trig_1");
    step(4'h1, 4'h1, 4'h0, "re_trig_2");
    step(4'h1, 4'h1, 4'h0, "re_trig_on");
    hold_time = 16'd2;
    step(4'h0, 4'h1, 4'h0, "reload_t2");
    hold_time = 16'd9;
    step(4'h0, 4'h1, 4'h1, "reload_t1_warn");
    step(4'h0, 4'h1, 4'h1, "reload_t0_warn");
    step(4'h0, 4'h0, 4'h0, "reload_off");

    // 5: daylight blocks turn-on but not an already lit zone
    daylight = 1'b1;
    for (int k = 0; k < 10; k++) step(4'h2, 4'h0, 4'h0, "day_block");
    step(4'h0, 4'h0, 4'h0, "day_pir_low");
    daylight = 1'b0;
    step(4'h4, 4'h0, 4'h0, "z2_on_1");
    step(4'h4, 4'h0, 4'h0, "z2_on_2");
    step(4'h4, 4'h4, 4'h0, "z2_on_3");
    daylight  = 1'b1;
    step(4'h4, 4'h4, 4'h0, "day_keeps_on");
    hold_time = 16'd1;
    step(4'h0, 4'h4, 4'h4, "day_hold_t1");
    step(4'h0, 4'h4, 4'h4, "day_hold_t0");
    step(4'h0, 4'h0, 4'h0, "day_hold_off");
    daylight = 1'b0;

    // 6: override, count, release, reset mid-HOLD
    step(4'h6, 4'h0, 4'h0, "z12_on_1");
    step(4'h6, 4'h0, 4'h0, "z12_on_2");
    step(4'h6, 4'h6, 4'h0, "z12_on_3");
    ovr_en  = 4'b0011;
    ovr_val = 4'b0001;
    now_chk(4'b0101, 4'h0, "ovr_apply");
    hold_time = 16'd2;
    step(4'h0, 4'b0101, 4'h0, "ovr_hold_t2");
    step(4'h0, 4'b0101, 4'b0100, "ovr_warn_masked");
    ovr_en = 4'b0000;
    now_chk(4'b0110, 4'b0110, "ovr_release");
    step(4'h0, 4'b0110, 4'b0110, "hold_t0_pre_rst");
    reset = 1'b1;
    now_chk(4'h0, 4'h0, "rst_mid_hold");
    step(4'h6, 4'h0, 4'h0, "rst_held");
    reset = 1'b0;
    step(4'h6, 4'h0, 4'h0, "post_rst_1");
    step(4'h6, 4'h0, 4'h0, "post_rst_2");
    step(4'h6, 4'h6, 4'h0, "post_rst_3_on");

    // Drain and confirm every expectation was consumed
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
